// File: rtl/pry2oht_drain_if.sv
// Handshake bundle for the priority drain: an input vector stream (s_*)
// and an output beat stream (m_*). The "master" modport is the drain
// itself: it consumes vectors and sources beats. The "slave" modport is
// the surrounding logic: it supplies vectors and sinks beats.
interface pry2oht_drain_if #(
    parameter int WIDTH = 32
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    logic                 s_vld;
    logic                 s_rdy;
    logic [WIDTH-1:0]     s_pry;
    logic                 m_vld;
    logic                 m_rdy;
    logic [WIDTH-1:0]     m_oht;
    logic [WIDTH_LOG-1:0] m_bin;
    logic [WIDTH_LOG-1:0] m_cnt;
    logic                 m_lst;

    modport master (
        input  s_vld, s_pry, m_rdy,
        output s_rdy, m_vld, m_oht, m_bin, m_cnt, m_lst
    );

    modport slave (
        output s_vld, s_pry, m_rdy,
        input  s_rdy, m_vld, m_oht, m_bin, m_cnt, m_lst
    );
endinterface

// File: rtl/pry2oht_drain.sv
// Sequential priority drain: accepts a request vector and emits each set
// bit as its own beat, lowest index first, with one-hot, binary index,
// per-vector ordinal and last flag. A new vector can be taken in the same
// cycle the previous vector's last beat is consumed, so there is no bubble.
module pry2oht_drain #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pry2oht_drain_if.master    bus
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH_LOG-1:0] cnt;

    logic [WIDTH-1:0]     oht;
    logic [WIDTH_LOG-1:0] bin;
    logic                 vld;
    logic                 lst;
    logic                 in_hs;
    logic                 out_hs;

    // Isolate the lowest remaining set bit; the negation is WIDTH bits wide
    // and its carry out is dropped.
    assign oht = rem & (~rem + WIDTH'(1));

    // Encode the isolated bit into its index (0 when nothing remains).
    always_comb begin
        // NOTE: default first so every path assigns bin and no latch is inferred.
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (oht[i]) begin
                bin = WIDTH_LOG'(i);
            end
        end
    end

    // BUSY is maintained alongside rem and always equals (rem != 0).
    assign vld    = (state == BUSY);
    assign lst    = ((rem & ~oht) == '0) & vld;
    assign out_hs = vld & bus.m_rdy;
    assign in_hs  = bus.s_vld & bus.s_rdy;

    assign bus.s_rdy = ~vld | (bus.m_rdy & lst);
    assign bus.m_vld = vld;
    assign bus.m_oht = oht;
    assign bus.m_bin = bin;
    assign bus.m_cnt = cnt;
    assign bus.m_lst = lst;

    // Load on input handshake (wins over a same-cycle beat), otherwise
    // strip the lowest bit and advance the ordinal on each output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples the pre-edge values regardless of statement order.
            state <= IDLE;
            rem   <= '0;
            cnt   <= '0;
        end else if (in_hs) begin
            rem   <= bus.s_pry;
            cnt   <= '0;
            state <= (bus.s_pry != '0) ? BUSY : IDLE;
        end else if (out_hs) begin
            rem   <= rem & ~oht;
            cnt   <= cnt + WIDTH_LOG'(1);
            state <= lst ? IDLE : BUSY;
        end
    end
endmodule

// File: doc/pry2oht_drain.md
# pry2oht_drain

Sequential priority drain. Accepts a priority (request) vector over a valid/ready handshake and emits every set bit as a separate output beat, rightmost (lowest index) first. Each beat carries a one-hot vector, its binary index, a per-vector beat ordinal and a last flag. The block is the consuming end of the codebase's priority-to-one-hot logic: instead of selecting only the single rightmost bit, it walks the whole vector. It sits between a request-collecting stage and a downstream consumer that services one request per beat.

## Interface
- `WIDTH`, default 32: vector width; must be at least 2.
- `WIDTH_LOG`, localparam `$clog2(WIDTH)`: width of the index and ordinal fields.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_vld`  in  1  input vector valid.
- `s_rdy`  out  1  input ready.
- `s_pry`  in  WIDTH  input priority vector.
- `m_vld`  out  1  output beat valid.
- `m_rdy`  in  1  output beat ready.
- `m_oht`  out  WIDTH  one-hot of the current lowest remaining set bit.
- `m_bin`  out  WIDTH_LOG  binary index of `m_oht`.
- `m_cnt`  out  WIDTH_LOG  ordinal of the beat within the current vector; the first beat is 0.
- `m_lst`  out  1  high when the current beat is the last set bit of the vector.

## Operation
- **State:**
  - remainder register `rem[WIDTH]`;
  - ordinal counter `cnt[WIDTH_LOG]`;
  - state IDLE or BUSY, where BUSY is exactly equivalent to `rem != 0`.
- **Output beat, derived combinationally from `rem`:**
  - `m_oht = rem & -rem`, computed modulo 2^WIDTH;
  - `m_bin` = index of the set bit in `m_oht`, or 0 when `rem == 0`;
  - `m_lst = ((rem & ~m_oht) == 0) & m_vld`;
  - `m_vld = (rem != 0)`;
  - `m_cnt = cnt`.
- **Ready:** `s_rdy = ~m_vld | (m_rdy & m_lst)`. This allows a new vector to be accepted in the same cycle the last beat of the previous vector completes. `s_rdy` therefore has a combinational path from `m_rdy`.
- **Output handshake** (`m_vld & m_rdy`):
  - `rem <= rem & ~m_oht`;
  - `cnt <= cnt + 1`.
- **Input handshake** (`s_vld & s_rdy`):
  - `rem <= s_pry`;
  - `cnt <= 0`.
  - This takes precedence over the output-handshake update when both occur in one cycle.
- **Zero vector:** an accepted `s_pry == 0` is consumed, produces no beat, and leaves the block in IDLE.
- **Transitions:**
  - IDLE -> BUSY on accepting a nonzero vector.
  - BUSY -> BUSY on a non-last output handshake.
  - BUSY -> IDLE on a last output handshake with no new vector accepted, or with a zero vector accepted.
  - BUSY -> BUSY (reloaded) on a last output handshake combined with acceptance of a nonzero vector.
- **Output stability:** while `m_vld & ~m_rdy`, all `m_*` outputs are held stable.
- **Reset (`rst_n` low, asynchronous):**
  - `rem = 0`, `cnt = 0`;
  - so `m_vld = 0`, `m_oht = 0`, `m_bin = 0`, `m_cnt = 0`, `m_lst = 0`, `s_rdy = 1`.
  - Reset asserted mid-vector discards all remaining bits; no further beats are emitted for that vector.

## Timing
- **Latency:** a vector accepted at edge N presents its first beat (`m_vld = 1`) in the cycle after edge N.
- **Throughput:**
  - one beat per cycle while `m_rdy = 1`;
  - a vector with k set bits occupies k cycles;
  - back-to-back vectors have no bubble.
- **Zero vector:** costs one acceptance cycle and no output cycles.
- **Back-pressure:** `m_rdy = 0` stalls indefinitely and loses no state.
- **Arithmetic:**
  - the two's-complement negation is WIDTH bits wide; the carry out is discarded;
  - `cnt` never exceeds WIDTH-1 within a vector, because at most WIDTH beats occur;
  - `cnt` wraps only when WIDTH is a power of two and all bits are set. In that case the wrap happens after the last beat and is harmless, because the next acceptance clears `cnt`.
- **Combinational paths:**
  - a path from `m_rdy` to `s_rdy` is permitted;
  - there is no path from `s_vld` or `s_pry` to any `m_*` output.

## Test plan
- **Basic drain (WIDTH=8):**
  - Stimulus: `s_pry = 8'b1010_0110`, `m_rdy = 1`.
  - Required response: beats (`m_oht`, `m_bin`, `m_cnt`, `m_lst`) = (0x02, 1, 0, 0), (0x04, 2, 1, 0), (0x20, 5, 2, 0), (0x80, 7, 3, 1), on 4 consecutive cycles starting the cycle after acceptance.
- **Back-pressure:**
  - Stimulus: same vector, with `m_rdy` low on alternating cycles.
  - Required response: the same 4 beats, each held stable while stalled; `s_rdy = 0` until the last handshake.
- **Back-to-back:**
  - Stimulus: `0x81` followed immediately by `0x01`, with `s_vld` held high.
  - Required response: the second vector is accepted in the same cycle as beat (0x80, 7, 1, 1); the next cycle shows (0x01, 0, 0, 1); no idle cycle between vectors.
- **Zero vector and full vector:**
  - Stimulus: `s_pry = 0x00`.
  - Required response: accepted, `m_vld` stays 0, `s_rdy` stays 1.
  - Stimulus: `s_pry = 0xFF`.
  - Required response: 8 beats, `m_bin` 0..7, `m_lst` high only on the 8th beat.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n = 0` asynchronously after the 2nd beat of `0xF0`.
  - Required response: outputs immediately return to `m_vld = 0`, `m_oht = 0`, `s_rdy = 1`; after release, a new `0x08` yields the single beat (0x08, 3, 0, 1).
- **Random regression:**
  - Stimulus: random vectors with random `m_rdy`.
  - Required response: the OR of all `m_oht` beats per vector equals `s_pry`; beats are strictly ascending in `m_bin`; the beat count equals `$countones(s_pry)`.
